teletype_iot_responder: RTL and testbench
=========================================

// Module: teletype_iot_responder
// PURPOSE
//  Responder end of the CPU's IOT bus for the console teletype.
//  Implements keyboard (device 03) and printer (device 04): decodes IOT requests and returns datain/skip/clear-AC.
//  On the host side it buffers keyboard characters in a FIFO and hands printer characters out over a valid/ready stream.
//  Sits beside the CPU; other device codes belong to other responders.
// PARAMETERS
//  KB_FIFO_DEPTH  8   keyboard FIFO entries; power of 2, >=2
//  PRINT_CYCLES   16  clocks after tx handshake before printer flag sets; >=1
//  DEV_KB         6'o03  keyboard device code
//  DEV_PR         6'o04  printer device code
// PORTS
//  clock        in   1  system clock, all logic on posedge
//  reset        in   1  asynchronous, active-high reset
//  iot_valid    in   1  one-cycle IOT request strobe from CPU
//  iot_device   in   6  IR[8:3], device select
//  iot_function in   3  IR[2:0]: bit0 IOP1, bit1 IOP2, bit2 IOP4
//  iot_dataout  in   8  AC[7:0] from CPU
//  iot_done     out  1  response strobe, asserted exactly 1 clock after accepted request
//  iot_datain   out  8  data ORed into AC by CPU; valid while iot_done
//  iot_skip     out  1  CPU does PC+2; valid while iot_done
//  iot_clear_ac out  1  CPU clears AC before OR; valid while iot_done
//  irq          out  1  kb_flag | pr_flag
//  kb_data      in   8  host keyboard character
//  kb_valid     in   1  host offers kb_data
//  kb_ready     out  1  FIFO not full; transfer when kb_valid & kb_ready
//  tx_data      out  8  printer character to host
//  tx_valid     out  1  held until tx_ready
//  tx_ready     in   1  host accepts tx_data
//  pr_overrun   out  1  sticky: TPC/TLS issued while printer busy
// BEHAVIOUR
//  Reset: all outputs 0 except kb_ready=1; FIFO empty; kb_flag=pr_flag=0; printer IDLE.
//  Accept: iot_valid & device in {DEV_KB,DEV_PR}. Other devices are ignored, with no iot_done.
//  Back-to-back requests are legal every cycle.
//  Response outputs are registered; they are 0 when iot_done=0.
//  Keyboard, applied in order IOP1, IOP2, IOP4:
//   - IOP1 (KSF): skip = kb_flag.
//   - IOP2 (KCC): clear_ac = 1, kb_flag <= 0.
//   - IOP4 (KRS): datain = kb_buffer.
//   - 6036 (KRB): clear_ac, datain = kb_buffer, kb_flag <= 0.
//  Keyboard load: when kb_flag=0 and FIFO not empty, pop into kb_buffer and set kb_flag <= 1 the next clock.
//   - A flag clear in cycle N allows the earliest reload in cycle N+1 (clear wins).
//   - FIFO push and pop in the same cycle are both legal, including when full.
//   - kb_ready deasserts when full; the host must hold the character.
//  Printer, IOP1 / IOP2 / IOP4:
//   - IOP1 (TSF): skip = pr_flag.
//   - IOP2 (TCF): pr_flag <= 0.
//   - IOP4 (TPC): load iot_dataout, start print.
//   - 6046 (TLS): clear flag and print.
//  Printer FSM:
//   - IDLE -> SEND on print start; tx_valid=1 and tx_data is stable until tx_ready.
//   - SEND -> WAIT on handshake; counter loads PRINT_CYCLES-1.
//   - WAIT -> IDLE at counter 0, with pr_flag <= 1 that clock.
//   - Print start while not IDLE: character dropped, pr_overrun <= 1, state unchanged.
//   - pr_overrun is cleared only by reset.
//  Simultaneous TCF and flag-set in the same clock: the flag set wins, so no completion is lost.
//  Reset mid-operation, async assert: FIFO contents discarded, tx_valid drops immediately, counter cleared.
//  Widths: counter is $clog2(PRINT_CYCLES+1) bits; FIFO pointers carry an extra wrap bit for full/empty.
// STRUCTURE
//  Shared package IOT_Definitions.pkg holds:
//   - DEV_* defaults;
//   - IOP1/IOP2/IOP4 bit-index constants;
//   - typedef enum {PR_IDLE, PR_SEND, PR_WAIT} printer_state_t.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH=KB_FIFO_DEPTH): push/pop/full/empty, async active-high reset.
//  The top holds the decode, flags, response registers and printer FSM.
// TESTING
//  1. Reset, then KSF (dev 03, fn 1) -> iot_done next clock, skip=0, datain=0.
//  2. Host pushes 8'h41; wait 2 clocks; KSF -> skip=1. KRB (fn 6) -> clear_ac=1, datain=8'h41; flag then 0.
//  3. Push 9 chars with FIFO full and flag set -> kb_ready=0 after 8 accepted. A KRB pops one, kb_ready returns to 1.
//  4. TLS (dev 04, fn 6) with AC=8'h5A, tx_ready held low 3 clocks:
//     -> tx_valid stays 1 and tx_data=8'h5A; pr_flag sets PRINT_CYCLES clocks after the handshake.
//  5. TPC during WAIT -> pr_overrun=1, no second tx_valid. TCF issued the same clock the flag sets -> pr_flag=1.
//  6. IOT to device 05 -> no iot_done. Assert reset mid-SEND -> tx_valid=0 and irq=0 immediately, kb_ready=1.

Source files
------------

// File: rtl/teletype_iot_responder_pkg.sv
// Shared definitions for the console teletype IOT responder.
// Device codes, IOP bit positions and printer FSM states.
package teletype_iot_responder_pkg;

  localparam logic [5:0] DEV_KB_DFLT = 6'o03;
  localparam logic [5:0] DEV_PR_DFLT = 6'o04;

  localparam int IOP1 = 0;
  localparam int IOP2 = 1;
  localparam int IOP4 = 2;

  typedef enum logic [1:0] {
    PR_IDLE,
    PR_SEND,
    PR_WAIT
  } printer_state_t;

endpackage

// File: rtl/teletype_iot_responder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// A push is taken when full if a pop happens in the same clock.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/teletype_iot_responder.sv
// Console teletype IOT responder: keyboard and printer devices.
// Decodes IOT requests, buffers host keys, streams printer characters.
module teletype_iot_responder
  import teletype_iot_responder_pkg::*;
#(
  parameter int         KB_FIFO_DEPTH = 8,
  parameter int         PRINT_CYCLES  = 16,
  parameter logic [5:0] DEV_KB        = DEV_KB_DFLT,
  parameter logic [5:0] DEV_PR        = DEV_PR_DFLT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iot_valid,
  input  logic [5:0] iot_device,
  input  logic [2:0] iot_function,
  input  logic [7:0] iot_dataout,
  output logic       iot_done,
  output logic [7:0] iot_datain,
  output logic       iot_skip,
  output logic       iot_clear_ac,
  output logic       irq,
  input  logic [7:0] kb_data,
  input  logic       kb_valid,
  output logic       kb_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       pr_overrun
);

  localparam int CW = $clog2(PRINT_CYCLES + 1);

  logic           done_q, done_d;
  logic [7:0]     datain_q, datain_d;
  logic           skip_q, skip_d;
  logic           clr_q, clr_d;
  logic           kb_flag_q, kb_flag_d;
  logic [7:0]     kb_buf_q, kb_buf_d;
  logic           pr_flag_q, pr_flag_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           ovr_q, ovr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  printer_state_t st_q, st_d;

  logic       kb_acc, pr_acc;
  logic       pr_start, pr_set;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  assign kb_acc = iot_valid & (iot_device == DEV_KB);
  assign pr_acc = iot_valid & (iot_device == DEV_PR);

  assign kb_ready     = ~fifo_full;
  assign iot_done     = done_q;
  assign iot_datain   = datain_q;
  assign iot_skip     = skip_q;
  assign iot_clear_ac = clr_q;
  assign irq          = kb_flag_q | pr_flag_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = (st_q == PR_SEND);
  assign pr_overrun   = ovr_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (KB_FIFO_DEPTH)
  ) u_kb_fifo (
    .clock (clock),
    .reset (reset),
    .push  (kb_valid & kb_ready),
    .wdata (kb_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    done_d    = kb_acc | pr_acc;
    datain_d  = '0;
    skip_d    = 1'b0;
    clr_d     = 1'b0;
    kb_flag_d = kb_flag_q;
    kb_buf_d  = kb_buf_q;
    fifo_pop  = 1'b0;

    if (kb_acc) begin
      skip_d = iot_function[IOP1] & kb_flag_q;
      clr_d  = iot_function[IOP2];
      if (iot_function[IOP4]) datain_d = kb_buf_q;
      if (iot_function[IOP2]) kb_flag_d = 1'b0;
    end

    // Reload looks at the registered flag, so a clear always lands first.
    if (!kb_flag_q && !fifo_empty) begin
      fifo_pop  = 1'b1;
      kb_buf_d  = fifo_rdata;
      kb_flag_d = 1'b1;
    end

    if (pr_acc) begin
      skip_d = iot_function[IOP1] & pr_flag_q;
    end
  end

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    ovr_d     = ovr_q;
    pr_flag_d = pr_flag_q;
    pr_set    = 1'b0;
    pr_start  = pr_acc & iot_function[IOP4];

    unique case (st_q)
      PR_IDLE: begin
        if (pr_start) begin
          st_d      = PR_SEND;
          tx_data_d = iot_dataout;
        end
      end
      PR_SEND: begin
        if (tx_ready) begin
          st_d  = PR_WAIT;
          cnt_d = CW'(PRINT_CYCLES - 1);
        end
      end
      PR_WAIT: begin
        if (cnt_q == '0) begin
          st_d   = PR_IDLE;
          pr_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: st_d = PR_IDLE;
    endcase

    if (pr_start && st_q != PR_IDLE) ovr_d = 1'b1;

    // Set beats clear so a completion is never lost.
    if (pr_acc && iot_function[IOP2]) pr_flag_d = 1'b0;
    if (pr_set) pr_flag_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      datain_q  <= '0;
      skip_q    <= 1'b0;
      clr_q     <= 1'b0;
      kb_flag_q <= 1'b0;
      kb_buf_q  <= '0;
      pr_flag_q <= 1'b0;
      tx_data_q <= '0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
      st_q      <= PR_IDLE;
    end else begin
      done_q    <= done_d;
      datain_q  <= datain_d;
      skip_q    <= skip_d;
      clr_q     <= clr_d;
      kb_flag_q <= kb_flag_d;
      kb_buf_q  <= kb_buf_d;
      pr_flag_q <= pr_flag_d;
      tx_data_q <= tx_data_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
    end
  end

endmodule

// File: tb/tb_teletype_iot_responder.sv
// Directed bench for the teletype IOT responder.
// Table of single IOT requests plus FIFO, printer and reset sequences.
module tb_teletype_iot_responder;

  localparam int PC = 16;

  logic       clock;
  logic       reset;
  logic       iot_valid;
  logic [5:0] iot_device;
  logic [2:0] iot_function;
  logic [7:0] iot_dataout;
  logic       iot_done;
  logic [7:0] iot_datain;
  logic       iot_skip;
  logic       iot_clear_ac;
  logic       irq;
  logic [7:0] kb_data;
  logic       kb_valid;
  logic       kb_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       pr_overrun;

  int checks = 0;
  int errors = 0;

  teletype_iot_responder #(
    .KB_FIFO_DEPTH (8),
    .PRINT_CYCLES  (PC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iot_valid    (iot_valid),
    .iot_device   (iot_device),
    .iot_function (iot_function),
    .iot_dataout  (iot_dataout),
    .iot_done     (iot_done),
    .iot_datain   (iot_datain),
    .iot_skip     (iot_skip),
    .iot_clear_ac (iot_clear_ac),
    .irq          (irq),
    .kb_data      (kb_data),
    .kb_valid     (kb_valid),
    .kb_ready     (kb_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .pr_overrun   (pr_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       push;
    logic [7:0] pdata;
    logic [5:0] dev;
    logic [2:0] fn;
    logic       done;
    logic [7:0] din;
    logic       skip;
    logic       clr;
    logic       irq;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic chk8(input string n, input logic [7:0] a,
                      input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  task automatic req(input logic [5:0] dev, input logic [2:0] fn,
                     input logic [7:0] ac);
    iot_valid    = 1'b1;
    iot_device   = dev;
    iot_function = fn;
    iot_dataout  = ac;
    step();
    iot_valid = 1'b0;
  endtask

  task automatic host_push(input logic [7:0] d);
    kb_data  = d;
    kb_valid = 1'b1;
    step();
    kb_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int k;

    tbl[0]  = '{1'b0, 8'h00, 6'o03, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 6'o05, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 6'o04, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 6'o03, 3'd2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'h41, 6'o03, 3'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 6'o03, 3'd4, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 6'o03, 3'd6, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 6'o03, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h7E, 6'o03, 3'd7, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 6'o03, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 6'o02, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    reset        = 1'b1;
    iot_valid    = 1'b0;
    iot_device   = '0;
    iot_function = '0;
    iot_dataout  = '0;
    kb_data      = '0;
    kb_valid     = 1'b0;
    tx_ready     = 1'b0;
    step();
    step();
    chk1("rst_done", iot_done, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    chk1("rst_kb_ready", kb_ready, 1'b1);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk1("rst_overrun", pr_overrun, 1'b0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].push) begin
        host_push(tbl[i].pdata);
        step();
        step();
      end
      req(tbl[i].dev, tbl[i].fn, 8'h00);
      chk1($sformatf("v%0d_done", i), iot_done, tbl[i].done);
      chk8($sformatf("v%0d_din", i), iot_datain, tbl[i].din);
      chk1($sformatf("v%0d_skip", i), iot_skip, tbl[i].skip);
      chk1($sformatf("v%0d_clr", i), iot_clear_ac, tbl[i].clr);
      chk1($sformatf("v%0d_irq", i), irq, tbl[i].irq);
    end

    // FIFO full: one char in buffer, eight in FIFO, ninth held off
    host_push(8'h30);
    step();
    step();
    chk1("ff_irq", irq, 1'b1);
    acc = 0;
    kb_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      kb_data = 8'h30 + 8'(i);
      if (!kb_ready) break;
      step();
      acc++;
    end
    chki("ff_accepted", acc, 8);
    chk1("ff_ready_low", kb_ready, 1'b0);
    req(6'o03, 3'd6, 8'h00);
    chk8("ff_krb_din", iot_datain, 8'h30);
    chk1("ff_krb_clr", iot_clear_ac, 1'b1);
    chk1("ff_still_full", kb_ready, 1'b0);
    step();
    chk1("ff_ready_back", kb_ready, 1'b1);
    chk1("ff_reload_irq", irq, 1'b1);
    step();
    kb_valid = 1'b0;
    chk1("ff_full_again", kb_ready, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      req(6'o03, 3'd6, 8'h00);
      chk8($sformatf("ff_drain%0d", i), iot_datain, 8'h30 + 8'(i));
      step();
    end
    chk1("ff_empty_irq", irq, 1'b0);
    chk1("ff_empty_ready", kb_ready, 1'b1);

    // TLS with a stalled host
    tx_ready = 1'b0;
    req(6'o04, 3'd6, 8'h5A);
    chk1("tls_done", iot_done, 1'b1);
    chk1("tls_clr", iot_clear_ac, 1'b0);
    chk8("tls_din", iot_datain, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("tls_valid%0d", i), tx_valid, 1'b1);
      chk8($sformatf("tls_data%0d", i), tx_data, 8'h5A);
      step();
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk1("tls_valid_drop", tx_valid, 1'b0);
    k = 0;
    for (int i = 1; i <= PC + 4; i++) begin
      step();
      if (irq) begin
        k = i;
        break;
      end
    end
    chki("tls_flag_delay", k, PC);
    req(6'o04, 3'd1, 8'h00);
    chk1("tsf_skip", iot_skip, 1'b1);
    req(6'o04, 3'd2, 8'h00);
    chk1("tcf_irq", irq, 1'b0);
    chk1("tcf_skip", iot_skip, 1'b0);

    // Overrun during WAIT, then TCF on the completion clock
    req(6'o04, 3'd4, 8'h11);
    chk1("tpc_valid", tx_valid, 1'b1);
    chk8("tpc_data", tx_data, 8'h11);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    req(6'o04, 3'd4, 8'h22);
    chk1("ovr_set", pr_overrun, 1'b1);
    chk1("ovr_no_valid", tx_valid, 1'b0);
    for (int i = 0; i < PC - 2; i++) step();
    chk1("ovr_pre_flag", irq, 1'b0);
    chk1("ovr_still_wait", tx_valid, 1'b0);
    req(6'o04, 3'd2, 8'h00);
    chk1("tcf_race_irq", irq, 1'b1);
    chk1("ovr_sticky", pr_overrun, 1'b1);
    chk1("ovr_no_second", tx_valid, 1'b0);
    req(6'o04, 3'd2, 8'h00);
    chk1("tcf_clear", irq, 1'b0);

    // Back-to-back requests to both devices
    iot_valid    = 1'b1;
    iot_device   = 6'o03;
    iot_function = 3'd1;
    step();
    chk1("b2b_done0", iot_done, 1'b1);
    iot_device = 6'o04;
    step();
    iot_valid = 1'b0;
    chk1("b2b_done1", iot_done, 1'b1);
    step();
    chk1("b2b_idle", iot_done, 1'b0);

    // Async reset in the middle of a send
    host_push(8'h55);
    step();
    host_push(8'h66);
    req(6'o04, 3'd4, 8'h77);
    chk1("mid_valid", tx_valid, 1'b1);
    chk1("mid_irq", irq, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("arst_valid", tx_valid, 1'b0);
    chk1("arst_irq", irq, 1'b0);
    chk1("arst_ready", kb_ready, 1'b1);
    chk1("arst_ovr", pr_overrun, 1'b0);
    reset = 1'b0;
    step();
    step();
    chk1("post_irq", irq, 1'b0);
    chk1("post_valid", tx_valid, 1'b0);
    chk1("post_done", iot_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
